aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Inverse AES-128 key schedule: loads the final (round-10) round key and walks the schedule backwards, producing one earlier round key per accepted handshake down to the cipher key (round 0). It sits in the decryption path next to the inverse cipher and is the decryption counterpart of the forward round-constant and key-expansion logic. Round constants are applied in reverse order, 0x36 down to 0x01. Round keys go out on a valid/ready interface so the inverse cipher can stall between rounds.

## Interface
- No parameters; AES-128 only.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- kld  in  1  load pulse; samples key_in
- key_in  in  128  round-10 key, w[40..43], word 0 in bits [127:96]
- out_ready  in  1  consumer accepts the current key_out
- key_out  out  128  current round key, same word order as key_in
- round  out  4  round index of key_out (10..0)
- out_valid  out  1  key_out/round are valid
- done  out  1  round-0 key has been accepted; schedule exhausted
- rewind  in  1  present only with AES_INV_KS_REWIND_EN

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on kld.
  - RUN → DONE on handshake while round == 0.
  - DONE → RUN on kld or on rewind.
  - kld in any state restarts RUN.
- Load: key_out ← key_in, round ← 10, out_valid ← 1, done ← 0.
- Step: occurs on handshake (out_valid && out_ready) with round > 0. With the current words W0..W3 and r = round:
  - n3 = W3^W2
  - n2 = W2^W1
  - n1 = W1^W0
  - n0 = W0 ^ SubWord(RotWord(n3)) ^ {rcon(r),24'h0}
  - key_out ← {n0,n1,n2,n3}, round ← r−1.
- rcon(r) for r = 1..10 is 01,02,04,08,10,20,40,80,1b,36.
- RotWord: byte rotate left ({b0,b1,b2,b3} → {b1,b2,b3,b0}).
- Handshake at round 0: out_valid ← 0, done ← 1. key_out and round hold their values.
- Priority: rst > kld > rewind > handshake.
- out_ready is ignored while out_valid = 0.
- All XOR is bytewise, with no carries. round never wraps below 0.

## Timing
- Reset values: key_out = 0, round = 0, out_valid = 0, done = 0, state IDLE.
- Reset is asynchronous and may assert mid-walk. The block returns to IDLE immediately; the first valid key after reset comes only from kld.
- kld in cycle t → key_out = key_in, round = 10, out_valid = 1 from t+1.
- One round per cycle when out_ready is held high: round 10 at t+1, round 0 at t+11, done = 1 from t+12.
- With out_ready low, key_out, round and out_valid hold indefinitely.
- kld during RUN, including in the same cycle as a handshake, discards the walk; the new key_in appears at the next cycle.
- Next-key logic is one combinational stage from the key_out register through 4 S-boxes. No pipeline bubbles.

## Configuration
- AES_INV_KS_REWIND_EN defined:
  - A 128-bit shadow register captures key_in on kld. Reset value is 0.
  - The rewind input reloads key_out from the shadow, with round = 10 and out_valid = 1 one cycle later, identical to a kld.
  - rewind is ignored before any kld since reset.
  - This allows multiple decryptions without re-supplying the key.
- Undefined: no shadow register and no rewind port; only kld restarts the walk.

## Structure
- Package aes_pkg contains:
  - state enum (IDLE/RUN/DONE)
  - 4-bit round type
  - rcon lookup function, round index → byte, returning 0 outside 1..10
- Sub-module: existing aes_sbox, instantiated 4× for SubWord. No other hierarchy.

## Test plan
- FIPS-197 A.1 walk:
  - kld with key_in = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 and out_ready = 1.
  - Round 9 = ac7766f3 19fadc21 28d12941 575c006e.
  - Round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - done = 1 at cycle 12.
- Backpressure:
  - Random out_ready after load.
  - Same 11 keys in order; key_out and round are stable while out_valid && !out_ready.
- Restart: kld at round 4 with a new key → next cycle round = 10 with the new key_in; no stale step.
- Reset: assert rst mid-walk (round 6) → key_out = 0, round = 0, out_valid = 0, done = 0 asynchronously; out_ready is then ignored.
- Completion:
  - After done, holding out_ready = 1 produces no changes.
  - kld from DONE restarts a full walk.
- Rewind (AES_INV_KS_REWIND_EN): rewind after done → round-10 key d014f9a8… re-emitted and the full A.1 walk repeats; rewind before any kld is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and helpers for the AES-128 inverse key
//               schedule: controller state encoding, round index type and
//               the round-constant lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [3:0] round_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_e;

    localparam round_t c_LAST_ROUND = 4'd10;

    // Round constant byte for round index 1..10; zero everywhere else.
    function automatic logic [7:0] rcon(input round_t r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box, one byte in, one byte out, purely
//               combinational table lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0x00 sits in the most significant byte of the table.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte n lives at bit offset 8*(255-n), which is simply {~n, 3'b000}.
    assign dout = c_SBOX[{~din, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_sched
// Description : AES-128 inverse key schedule. Loads the round-10 key and
//               steps backwards one round key per valid/ready handshake
//               down to the cipher key (round 0).
//               Optional feature macro: AES_INV_KS_REWIND_EN adds a shadow
//               copy of the loaded key and a rewind input that restarts the
//               walk from it.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key_in,
    input  logic         out_ready,
`ifdef AES_INV_KS_REWIND_EN
    input  logic         rewind,
`endif
    output logic [127:0] key_out,
    output round_t       round,
    output logic         out_valid,
    output logic         done
);

    ks_state_e    r_state;
    ks_state_e    w_state_nxt;

    logic         w_reload;
    logic [127:0] w_load_key;
    logic         w_handshake;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [127:0] w_key_nxt;

    // Valid and done are direct decodes of the controller state.
    assign out_valid   = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign w_handshake = out_valid & out_ready;

`ifdef AES_INV_KS_REWIND_EN
    logic [127:0] r_shadow;
    logic         r_shadow_vld;

    // Keep a copy of the last loaded key so a later walk needs no reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
        end else if (kld) begin
            r_shadow     <= key_in;
            r_shadow_vld <= 1'b1;
        end
    end

    // kld wins over rewind; rewind means nothing until a key was loaded.
    assign w_reload   = kld | (rewind & r_shadow_vld);
    assign w_load_key = kld ? key_in : r_shadow;
`else
    assign w_reload   = kld;
    assign w_load_key = key_in;
`endif

    // Previous round key: the three low words undo the forward XOR chain,
    // word 0 undoes the SubWord/RotWord/rcon term using the new word 3.
    assign w_w0 = key_out[127:96];
    assign w_w1 = key_out[95:64];
    assign w_w2 = key_out[63:32];
    assign w_w3 = key_out[31:0];

    assign w_n3  = w_w3 ^ w_w2;
    assign w_n2  = w_w2 ^ w_w1;
    assign w_n1  = w_w1 ^ w_w0;
    assign w_rot = {w_n3[23:0], w_n3[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (w_rot[8*i +: 8]),
                .dout (w_sub[8*i +: 8])
            );
        end
    endgenerate

    assign w_n0      = w_w0 ^ w_sub ^ {rcon(round), 24'h000000};
    assign w_key_nxt = {w_n0, w_n1, w_n2, w_n3};

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any load restarts the walk; the round-0 handshake ends it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_reload) begin
            w_state_nxt = RUN;
        end else if ((r_state == RUN) && w_handshake && (round == 4'd0)) begin
            w_state_nxt = DONE;
        end
    end

    // Round key and index: load, or step back one round per handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_out <= '0;
            round   <= '0;
        end else if (w_reload) begin
            key_out <= w_load_key;
            round   <= c_LAST_ROUND;
        end else if (w_handshake && (round != 4'd0)) begin
            key_out <= w_key_nxt;
            round   <= round - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_sched
// Description : Self-checking bench for aes_inv_key_sched. A word-level
//               FIPS-197 schedule model (S-box derived from GF(2^8)
//               arithmetic) predicts every output on every cycle; directed
//               literal vectors pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_sched;

    localparam logic [127:0] c_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] c_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_KA  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_KB  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         kld = 1'b0;
    logic         out_ready = 1'b0;
    logic         rewind = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] key_out;
    logic [3:0]   round;
    logic         out_valid;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .kld       (kld),
        .key_in    (key_in),
        .out_ready (out_ready),
`ifdef AES_INV_KS_REWIND_EN
        .rewind    (rewind),
`endif
        .key_out   (key_out),
        .round     (round),
        .out_valid (out_valid),
        .done      (done)
    );

    // ---------------- reference arithmetic ----------------
    logic [7:0]   s_tab [256];
    logic [127:0] m_sched [11];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_gf(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] g_word(input logic [31:0] t, input int rnd);
        logic [31:0] s;
        logic [7:0]  rc = 8'h01;
        for (int j = 1; j < rnd; j++) rc = xtime(rc);
        s = {s_tab[t[23:16]], s_tab[t[15:8]], s_tab[t[7:0]], s_tab[t[31:24]]};
        return s ^ {rc, 24'h000000};
    endfunction

    // Run the word recurrence of FIPS-197 backwards from w[40..43].
    task automatic build_sched(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = g_word(t, i / 4);
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Ordinary forward expansion, used to cross-check the backward walk.
    task automatic fwd_expand(input logic [127:0] k0, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[j] = k0[127-32*j -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = g_word(t, i / 4);
            w[i] = w[i-4] ^ t;
        end
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- transaction model ----------------
    logic [127:0] m_key = '0;
    logic [127:0] m_shadow = '0;
    int           m_round = 0;
    bit           m_valid = 1'b0;
    bit           m_done = 1'b0;
    bit           m_shadow_ok = 1'b0;

    task automatic m_load(input logic [127:0] k);
        build_sched(k);
        m_key   = k;
        m_round = 10;
        m_valid = 1'b1;
        m_done  = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_key = '0; m_round = 0; m_valid = 1'b0; m_done = 1'b0;
            m_shadow = '0; m_shadow_ok = 1'b0;
        end else if (kld) begin
            m_load(key_in);
            m_shadow    = key_in;
            m_shadow_ok = 1'b1;
        end
`ifdef AES_INV_KS_REWIND_EN
        else if (rewind && m_shadow_ok) begin
            m_load(m_shadow);
        end
`endif
        else if (m_valid && out_ready) begin
            if (m_round > 0) begin
                m_round = m_round - 1;
                m_key   = m_sched[m_round];
            end else begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        chk("cyc_out_valid", {127'd0, out_valid}, {127'd0, m_valid});
        chk("cyc_done",      {127'd0, done},      {127'd0, m_done});
        chk("cyc_round",     {124'd0, round},     {124'd0, m_round[3:0]});
        chk("cyc_key_out",   key_out,             m_key);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input int target);
        int k = 0;
        while (!(out_valid && round == 4'(target)) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) timeout_fail("wait_round");
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) timeout_fail("wait_done");
    endtask

    logic [127:0] hold_key;
    logic [3:0]   hold_round;
    logic [127:0] k_chk;
    bit           held;

    initial begin
        // pin the reference model with published values
        for (int i = 0; i < 256; i++) s_tab[i] = sbox_gf(8'(i));
        chk("pin_sbox_00", {120'd0, s_tab[8'h00]}, {120'd0, 8'h63});
        chk("pin_sbox_53", {120'd0, s_tab[8'h53]}, {120'd0, 8'hed});
        build_sched(c_K10);
        chk("pin_model_r9", m_sched[9], c_R9);
        chk("pin_model_r0", m_sched[0], c_R0);
        fwd_expand(m_sched[0], k_chk);
        chk("pin_model_fwd", k_chk, c_K10);

        // reset
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("reset_key", key_out, '0);
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        rst = 1'b1;
        tick();

`ifdef AES_INV_KS_REWIND_EN
        rewind = 1'b1; tick(); rewind = 1'b0; tick();
        chk("rewind_before_kld", {127'd0, out_valid}, 128'd0);
`endif

        // FIPS-197 A.1 walk at full rate
        out_ready = 1'b1; key_in = c_K10; kld = 1'b1;
        tick(); kld = 1'b0;
        chk("a1_round10", {124'd0, round}, 128'd10);
        chk("a1_key10", key_out, c_K10);
        tick();
        chk("a1_key9", key_out, c_R9);
        repeat (9) tick();
        chk("a1_round0", {124'd0, round}, 128'd0);
        chk("a1_key0", key_out, c_R0);
        chk("a1_not_done_yet", {127'd0, done}, 128'd0);
        tick();
        chk("a1_done_cycle12", {127'd0, done}, 128'd1);
        chk("a1_valid_off", {127'd0, out_valid}, 128'd0);
        repeat (5) tick();
        chk("done_hold_key", key_out, c_R0);
        chk("done_hold_flag", {127'd0, done}, 128'd1);

        // reload from DONE, random backpressure
        kld = 1'b1; out_ready = 1'b0; tick(); kld = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            out_ready  = 1'($urandom_range(0, 1));
            hold_key   = key_out;
            hold_round = round;
            held       = out_valid && !out_ready;
            tick();
            if (held) begin
                chk("bp_hold_key", key_out, hold_key);
                chk("bp_hold_round", {124'd0, round}, {124'd0, hold_round});
            end
        end
        if (!done) timeout_fail("bp_walk");
        chk("bp_final_key", key_out, c_R0);

        // restart in mid-walk, together with a handshake
        out_ready = 1'b1; key_in = c_KA; kld = 1'b1; tick(); kld = 1'b0;
        wait_round(4);
        key_in = c_KB; kld = 1'b1; tick(); kld = 1'b0;
        chk("restart_round", {124'd0, round}, 128'd10);
        chk("restart_key", key_out, c_KB);
        tick();
        chk("restart_step", {124'd0, round}, 128'd9);

        // asynchronous reset in mid-walk
        key_in = c_K10; kld = 1'b1; tick(); kld = 1'b0;
        wait_round(6);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_key", key_out, '0);
        chk("async_rst_round", {124'd0, round}, 128'd0);
        chk("async_rst_valid", {127'd0, out_valid}, 128'd0);
        chk("async_rst_done", {127'd0, done}, 128'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", {127'd0, out_valid}, 128'd0);

`ifdef AES_INV_KS_REWIND_EN
        key_in = c_K10; kld = 1'b1; tick(); kld = 1'b0;
        key_in = c_KA;
        wait_done();
        rewind = 1'b1; tick(); rewind = 1'b0;
        chk("rewind_round", {124'd0, round}, 128'd10);
        chk("rewind_key", key_out, c_K10);
        tick();
        chk("rewind_key9", key_out, c_R9);
        wait_done();
        chk("rewind_key0", key_out, c_R0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
